i2c_wb_regs: RTL and testbench
==============================

# i2c_wb_regs

Wishbone slave register file for the I2C master core. It is the RTL stage directly downstream of the WB agent. It accepts 8-bit Wishbone classic single-cycle reads and writes and holds the prescale, control, transmit and command registers. It reports receive data and status back to the bus and drives the byte/bit controller's command inputs. It also generates the interrupt request.

## Interface
- ADDR_W, 3, Wishbone address width (register index).
- DATA_W, 8, Wishbone data width; only 8 is supported.
- wb_clk_i  in  1  clock. This is the block's only clock.
- wb_rst_n_i  in  1  reset, synchronous and active-low.
- wb_adr_i  in  ADDR_W  register index.
- wb_dat_i / wb_dat_o  in / out  DATA_W  write data / read data.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1  Wishbone write enable, strobe, cycle.
- wb_ack_o  out  1  transfer acknowledge.
- wb_inta_o  out  1  interrupt request.
- prescale_o  out  16  SCL prescale value {PRERhi, PRERlo}.
- core_en_o, ien_o  out  1  CTR.EN and CTR.IEN.
- txr_o  out  8  transmit byte.
- cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o  out  1  command bits to the byte controller.
- rxr_i  in  8  received byte.
- done_i, al_i  in  1  single-cycle pulses: byte command done, arbitration lost.
- irxack_i, busy_i, tip_i  in  1  received ACK bit, bus busy, transfer in progress (levels).

## Operation
- Register map:
  - 0 PRERlo: read/write, reset 0xFF.
  - 1 PRERhi: read/write, reset 0xFF.
  - 2 CTR: read/write, reset 0x00. Bit 7 is EN, bit 6 is IEN; the other bits read 0.
  - 3: write goes to TXR (reset 0x00); read returns RXR (rxr_i).
  - 4: write goes to CR; read returns SR.
  - 5–7: reads return 0x00, writes are ignored, and the access is still acknowledged.
- PRERlo and PRERhi writes are ignored while EN=1.
- CR write bits: 7 STA, 6 STO, 5 RD, 4 WR, 3 ACK, 0 IACK. CR writes are ignored while EN=0.
- STA, STO, RD and WR are held until done_i or al_i, then auto-clear. The clear takes priority over a same-cycle CR write for those four bits.
- ACK holds its written value.
- IACK is self-clearing. It is high for exactly one cycle after the write, and is not visible on any port.
- SR read bits: 7 RxACK (irxack_i), 6 Busy (busy_i), 5 AL, 4:2 read 0, 1 TIP (tip_i), 0 IF.
- IF flag:
  - Set on done_i or al_i.
  - Cleared by an IACK write.
  - If set and clear happen in the same cycle, set wins.
- AL flag:
  - Set on al_i.
  - Cleared by a CR write with STA=1.
  - If set and clear happen in the same cycle, set wins.
- wb_inta_o is a registered copy of IF & IEN.

## Timing
- Reset values:
  - wb_ack_o=0, wb_dat_o=0x00, wb_inta_o=0.
  - prescale_o=0xFFFF.
  - All cmd_* outputs 0, core_en_o=0, ien_o=0, txr_o=0.
  - IF=0, AL=0.
- Acknowledge:
  - A request is wb_cyc_i & wb_stb_i high at edge N.
  - wb_ack_o is high in cycle N+1, for exactly one cycle.
  - It is computed as cyc & stb & ~ack, so it always drops for at least one cycle, even if wb_stb_i stays high.
  - Back-to-back accesses therefore take 2 cycles each.
- Write commit: occurs on the edge that ends the ack cycle, i.e. when cyc & stb & we & ack are all high. Register outputs change on that edge.
- Read: wb_dat_o is registered and valid during the ack cycle. It reflects the status inputs as sampled at edge N.
- Command clear: done_i high at edge M forces the STA/STO/RD/WR bits to 0 after edge M. IF is 1 after edge M. wb_inta_o is high after edge M+1.
- Reset mid-transfer: on the first low-reset edge, all state returns to its reset value and any pending ack is dropped. The master must reissue the access.
- wb_cyc_i=0 with wb_stb_i=1 is not a request.

## Configuration
- Macro I2C_WB_ERR_EN.
- Defined:
  - Adds output port wb_err_o.
  - Accesses to addresses 5–7, PRER writes while EN=1, and CR writes while EN=0 get wb_err_o instead of wb_ack_o.
  - The error response uses the same timing and one-cycle pulse rule as ack.
- Not defined: no wb_err_o port; those accesses are silently acknowledged as described in Operation.

## Structure
- Package i2c_wb_regs_pkg holds:
  - Register address localparams.
  - CTR, CR and SR bit-position constants.
  - Reset values (PRER_RST=8'hFF).
  - A packed struct i2c_cmd_t {sta, sto, rd, wr, ack}.
- One sub-module, i2c_wb_cmd_stat, holds the CR command bits, the IACK pulse and the IF/AL flags with their set/clear priority.
- The top level holds the bus handshake, address decode, the PRER/CTR/TXR registers and the read mux.

## Test plan
- Reset: read addresses 0–4 -> 0xFF, 0xFF, 0x00, rxr_i, {irxack_i, busy_i, 0, 000, tip_i, 0}. wb_inta_o=0.
- EN=0:
  - Write PRERlo=0x63 and PRERhi=0x00 -> prescale_o=0x0063.
  - Then write CTR=0x80.
  - Then write PRERlo=0x10 -> prescale_o stays 0x0063.
- With EN=1:
  - Write CR=0x90 (STA+WR) -> cmd_sta_o=cmd_wr_o=1.
  - Pulse done_i -> both clear, SR.IF=1.
  - Set CTR=0xC0 -> wb_inta_o=1.
  - Write CR=0x01 -> IF=0, wb_inta_o=0.
- Write CR=0x01 in the same cycle as done_i -> IF remains 1.
- Pulse al_i -> SR=0x21 (AL and IF set), STA/STO/RD/WR clear. A CR write of 0x80 clears AL.
- Hold stb high for 6 cycles -> ack pulses in cycles 2, 4 and 6. Assert reset during an ack cycle -> ack=0 on the next edge.
- With I2C_WB_ERR_EN, read address 6 -> wb_err_o pulses and wb_ack_o stays 0.

Source files
------------

// File: rtl/i2c_wb_regs_pkg.sv
// Shared constants and types for the I2C master Wishbone register file.
// Register indices, register bit positions, reset values and the command bundle.
package i2c_wb_regs_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADR_PRERLO  = 3'd0;
   localparam logic [ADDR_W-1:0] ADR_PRERHI  = 3'd1;
   localparam logic [ADDR_W-1:0] ADR_CTR     = 3'd2;
   localparam logic [ADDR_W-1:0] ADR_TXR_RXR = 3'd3;
   localparam logic [ADDR_W-1:0] ADR_CR_SR   = 3'd4;

   localparam int CTR_EN  = 7;
   localparam int CTR_IEN = 6;

   localparam int CR_STA  = 7;
   localparam int CR_STO  = 6;
   localparam int CR_RD   = 5;
   localparam int CR_WR   = 4;
   localparam int CR_ACK  = 3;
   localparam int CR_IACK = 0;

   localparam int SR_RXACK = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_AL    = 5;
   localparam int SR_TIP   = 1;
   localparam int SR_IF    = 0;

   localparam logic [DATA_W-1:0] PRER_RST = 8'hFF;
   localparam logic [DATA_W-1:0] TXR_RST  = 8'h00;

   typedef struct packed {
      logic sta;
      logic sto;
      logic rd;
      logic wr;
      logic ack;
   } i2c_cmd_t;

endpackage

// File: rtl/i2c_wb_regs_if.sv
// Wishbone classic 8-bit slave bus bundle for the I2C register file.
// wb_err_o exists only when I2C_WB_ERR_EN is defined.
interface i2c_wb_regs_if;
   import i2c_wb_regs_pkg::*;

   logic [ADDR_W-1:0] wb_adr_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic [DATA_W-1:0] wb_dat_o;
   logic              wb_we_i;
   logic              wb_stb_i;
   logic              wb_cyc_i;
   logic              wb_ack_o;
`ifdef I2C_WB_ERR_EN
   logic              wb_err_o;
`endif

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
`ifdef I2C_WB_ERR_EN
      input  wb_err_o,
`endif
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
`ifdef I2C_WB_ERR_EN
      output wb_err_o,
`endif
      output wb_dat_o, wb_ack_o
   );

endinterface

// File: rtl/i2c_wb_cmd_stat.sv
// Command register bits, IACK pulse and the IF/AL status flags.
// A done/al event always wins over a same-cycle write or acknowledge.
module i2c_wb_cmd_stat
   import i2c_wb_regs_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     cr_we,
   input  i2c_cmd_t cr_cmd,
   input  logic     cr_iack,
   input  logic     done_i,
   input  logic     al_i,
   output i2c_cmd_t cmd,
   output logic     if_flag,
   output logic     al_flag
);

   logic iack;
   logic cmd_clr;

   assign cmd_clr = done_i | al_i;

   // Start/stop/read/write are held until the byte controller finishes or loses arbitration.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd     <= '0;
         iack    <= 1'b0;
         if_flag <= 1'b0;
         al_flag <= 1'b0;
      end else begin
         if (cmd_clr) begin
            cmd.sta <= 1'b0;
            cmd.sto <= 1'b0;
            cmd.rd  <= 1'b0;
            cmd.wr  <= 1'b0;
         end else if (cr_we) begin
            cmd.sta <= cr_cmd.sta;
            cmd.sto <= cr_cmd.sto;
            cmd.rd  <= cr_cmd.rd;
            cmd.wr  <= cr_cmd.wr;
         end

         if (cr_we)
            cmd.ack <= cr_cmd.ack;

         iack <= cr_we & cr_iack;

         if (cmd_clr)
            if_flag <= 1'b1;
         else if (iack)
            if_flag <= 1'b0;

         if (al_i)
            al_flag <= 1'b1;
         else if (cr_we & cr_cmd.sta)
            al_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/i2c_wb_regs.sv
// Wishbone slave register file for the I2C master core (PRER, CTR, TXR/RXR, CR/SR).
// Define I2C_WB_ERR_EN to answer illegal accesses with wb_err_o instead of wb_ack_o.
module i2c_wb_regs
   import i2c_wb_regs_pkg::*;
(
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   i2c_wb_regs_if.slave        wb,
   output logic                wb_inta_o,
   output logic [15:0]         prescale_o,
   output logic                core_en_o,
   output logic                ien_o,
   output logic [DATA_W-1:0]   txr_o,
   output logic                cmd_sta_o,
   output logic                cmd_sto_o,
   output logic                cmd_rd_o,
   output logic                cmd_wr_o,
   output logic                cmd_ack_o,
   input  logic [DATA_W-1:0]   rxr_i,
   input  logic                done_i,
   input  logic                al_i,
   input  logic                irxack_i,
   input  logic                busy_i,
   input  logic                tip_i
);

   logic [DATA_W-1:0] prer_lo;
   logic [DATA_W-1:0] prer_hi;
   logic [DATA_W-1:0] txr;
   logic [DATA_W-1:0] rd_mux;
   logic [DATA_W-1:0] dat_q;
   logic              ctr_en;
   logic              ctr_ien;
   logic              ack_q;
   logic              req;
   logic              resp;
   logic              bad_access;
   logic              wr_commit;
   logic              cr_we;
   logic              if_flag;
   logic              al_flag;
   logic              inta_q;
   i2c_cmd_t          cmd;
   i2c_cmd_t          cr_wr_cmd;

   assign req = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef I2C_WB_ERR_EN
   logic err_q;

   // Undecoded addresses and writes the current EN state would discard are flagged as errors.
   always_comb begin
      bad_access = 1'b0;
      case (wb.wb_adr_i)
         ADR_PRERLO, ADR_PRERHI: bad_access = wb.wb_we_i & ctr_en;
         ADR_CTR, ADR_TXR_RXR:   bad_access = 1'b0;
         ADR_CR_SR:              bad_access = wb.wb_we_i & ~ctr_en;
         default:                bad_access = 1'b1;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i)
         err_q <= 1'b0;
      else
         err_q <= req & ~resp & bad_access;
   end

   assign resp        = ack_q | err_q;
   assign wb.wb_err_o = err_q;
`else
   assign bad_access = 1'b0;
   assign resp       = ack_q;
`endif

   // Terminations are single-cycle pulses; the read word is captured with the request.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         ack_q  <= 1'b0;
         dat_q  <= '0;
         inta_q <= 1'b0;
      end else begin
         ack_q  <= req & ~resp & ~bad_access;
         inta_q <= if_flag & ctr_ien;
         if (req & ~resp)
            dat_q <= rd_mux;
      end
   end

   assign wr_commit = req & wb.wb_we_i & ack_q;
   assign cr_we     = wr_commit & (wb.wb_adr_i == ADR_CR_SR) & ctr_en;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         prer_lo <= PRER_RST;
         prer_hi <= PRER_RST;
         ctr_en  <= 1'b0;
         ctr_ien <= 1'b0;
         txr     <= TXR_RST;
      end else if (wr_commit) begin
         case (wb.wb_adr_i)
            ADR_PRERLO:  if (!ctr_en) prer_lo <= wb.wb_dat_i;
            ADR_PRERHI:  if (!ctr_en) prer_hi <= wb.wb_dat_i;
            ADR_CTR: begin
               ctr_en  <= wb.wb_dat_i[CTR_EN];
               ctr_ien <= wb.wb_dat_i[CTR_IEN];
            end
            ADR_TXR_RXR: txr <= wb.wb_dat_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (wb.wb_adr_i)
         ADR_PRERLO:  rd_mux = prer_lo;
         ADR_PRERHI:  rd_mux = prer_hi;
         ADR_CTR: begin
            rd_mux[CTR_EN]  = ctr_en;
            rd_mux[CTR_IEN] = ctr_ien;
         end
         ADR_TXR_RXR: rd_mux = rxr_i;
         ADR_CR_SR: begin
            rd_mux[SR_RXACK] = irxack_i;
            rd_mux[SR_BUSY]  = busy_i;
            rd_mux[SR_AL]    = al_flag;
            rd_mux[SR_TIP]   = tip_i;
            rd_mux[SR_IF]    = if_flag;
         end
         default: rd_mux = '0;
      endcase
   end

   assign cr_wr_cmd = '{sta: wb.wb_dat_i[CR_STA], sto: wb.wb_dat_i[CR_STO],
                        rd:  wb.wb_dat_i[CR_RD],  wr:  wb.wb_dat_i[CR_WR],
                        ack: wb.wb_dat_i[CR_ACK]};

   i2c_wb_cmd_stat u_cmd_stat (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .cr_we   (cr_we),
      .cr_cmd  (cr_wr_cmd),
      .cr_iack (wb.wb_dat_i[CR_IACK]),
      .done_i  (done_i),
      .al_i    (al_i),
      .cmd     (cmd),
      .if_flag (if_flag),
      .al_flag (al_flag)
   );

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign wb_inta_o   = inta_q;
   assign prescale_o  = {prer_hi, prer_lo};
   assign core_en_o   = ctr_en;
   assign ien_o       = ctr_ien;
   assign txr_o       = txr;
   assign cmd_sta_o   = cmd.sta;
   assign cmd_sto_o   = cmd.sto;
   assign cmd_rd_o    = cmd.rd;
   assign cmd_wr_o    = cmd.wr;
   assign cmd_ack_o   = cmd.ack;

endmodule

// File: tb/tb_i2c_wb_regs.sv
// Self-checking bench for i2c_wb_regs: directed vector table, hand-written corner
// sequences and a randomized phase against a register-level reference model.
module tb_i2c_wb_regs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_inta_o;
   logic [15:0] prescale_o;
   logic        core_en_o, ien_o;
   logic [7:0]  txr_o;
   logic        cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o;
   logic [7:0]  rxr_i = 8'h00;
   logic        done_i = 1'b0, al_i = 1'b0;
   logic        irxack_i = 1'b0, busy_i = 1'b0, tip_i = 1'b0;
   logic        err_sig;

   int checks = 0;
   int failures = 0;

   i2c_wb_regs_if bus ();

   i2c_wb_regs dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb         (bus),
      .wb_inta_o  (wb_inta_o),
      .prescale_o (prescale_o),
      .core_en_o  (core_en_o),
      .ien_o      (ien_o),
      .txr_o      (txr_o),
      .cmd_sta_o  (cmd_sta_o),
      .cmd_sto_o  (cmd_sto_o),
      .cmd_rd_o   (cmd_rd_o),
      .cmd_wr_o   (cmd_wr_o),
      .cmd_ack_o  (cmd_ack_o),
      .rxr_i      (rxr_i),
      .done_i     (done_i),
      .al_i       (al_i),
      .irxack_i   (irxack_i),
      .busy_i     (busy_i),
      .tip_i      (tip_i)
   );

`ifdef I2C_WB_ERR_EN
   assign err_sig = bus.wb_err_o;
`else
   assign err_sig = 1'b0;
`endif

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model state: the architectural registers as seen by software
   logic [15:0] m_prer;
   logic        m_en, m_ien;
   logic [7:0]  m_txr;
   logic [4:0]  m_cmd;
   logic        m_if, m_al;

   typedef struct {
      logic        we;
      logic [2:0]  adr;
      logic [7:0]  data;
      logic [7:0]  exp_rd;
      logic [15:0] exp_presc;
   } vec_t;

   vec_t vecs[10];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_outs();
      return {prescale_o, core_en_o, ien_o, txr_o,
              cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o, wb_inta_o};
   endfunction

   function automatic logic [31:0] model_outs();
      return {m_prer, m_en, m_ien, m_txr, m_cmd, m_if & m_ien};
   endfunction

   // One complete Wishbone access; returns read data and {err, ack} at the response sample
   task automatic apply_stimulus(input logic we, input logic [2:0] adr, input logic [7:0] wdat,
                                 output logic [7:0] rdat, output logic [1:0] resp);
      bit seen = 0;
      rdat = '0;
      resp = 2'b00;
      @(negedge clk);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = wdat;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(posedge clk); #1;
         if (bus.wb_ack_o || err_sig) begin
            seen = 1;
            rdat = bus.wb_dat_o;
            resp = {err_sig, bus.wb_ack_o};
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL bus_timeout adr=%0d actual=no response required=termination", adr);
      end
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse(input logic d, input logic a);
      @(negedge clk);
      done_i = d;
      al_i   = a;
      @(negedge clk);
      done_i = 1'b0;
      al_i   = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic model_reset();
      m_prer = 16'hFFFF; m_en = 0; m_ien = 0; m_txr = 0; m_cmd = 0; m_if = 0; m_al = 0;
   endtask

   function automatic logic model_bad(input logic we, input logic [2:0] adr);
`ifdef I2C_WB_ERR_EN
      return (adr > 3'd4) || (we && adr <= 3'd1 && m_en) || (we && adr == 3'd4 && !m_en);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] model_read(input logic [2:0] adr);
      case (adr)
         3'd0: return m_prer[7:0];
         3'd1: return m_prer[15:8];
         3'd2: return {m_en, m_ien, 6'b0};
         3'd3: return rxr_i;
         3'd4: return {irxack_i, busy_i, m_al, 3'b000, tip_i, m_if};
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_write(input logic [2:0] adr, input logic [7:0] d);
      case (adr)
         3'd0: if (!m_en) m_prer[7:0] = d;
         3'd1: if (!m_en) m_prer[15:8] = d;
         3'd2: begin m_en = d[7]; m_ien = d[6]; end
         3'd3: m_txr = d;
         3'd4: if (m_en) begin
            m_cmd = d[7:3];
            if (d[0]) m_if = 1'b0;
            if (d[7]) m_al = 1'b0;
         end
         default: ;
      endcase
   endtask

   initial begin
      logic [7:0] rd;
      logic [1:0] resp;
      logic       pre;

      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      bus.wb_adr_i = '0; bus.wb_dat_i = '0;

      vecs[0] = '{1'b0, 3'd0, 8'h00, 8'hFF, 16'hFFFF};
      vecs[1] = '{1'b0, 3'd1, 8'h00, 8'hFF, 16'hFFFF};
      vecs[2] = '{1'b0, 3'd2, 8'h00, 8'h00, 16'hFFFF};
      vecs[3] = '{1'b0, 3'd3, 8'h00, 8'h5A, 16'hFFFF};
      vecs[4] = '{1'b0, 3'd4, 8'h00, 8'hC2, 16'hFFFF};
      vecs[5] = '{1'b1, 3'd0, 8'h63, 8'h00, 16'hFF63};
      vecs[6] = '{1'b1, 3'd1, 8'h00, 8'h00, 16'h0063};
      vecs[7] = '{1'b1, 3'd2, 8'h80, 8'h00, 16'h0063};
      vecs[8] = '{1'b1, 3'd0, 8'h10, 8'h00, 16'h0063};
      vecs[9] = '{1'b0, 3'd0, 8'h00, 8'h63, 16'h0063};

      do_reset();
      check_output("reset_outs", dut_outs(), {16'hFFFF, 16'h0000});
      check_output("reset_dat_o", {24'h0, bus.wb_dat_o}, 32'h0);

      rxr_i = 8'h5A; irxack_i = 1; busy_i = 1; tip_i = 1;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].we, vecs[i].adr, vecs[i].data, rd, resp);
         if (!vecs[i].we)
            check_output($sformatf("vec%0d_rd", i), {24'h0, rd}, {24'h0, vecs[i].exp_rd});
         check_output($sformatf("vec%0d_presc", i), {16'h0, prescale_o}, {16'h0, vecs[i].exp_presc});
      end
      check_output("en_after_ctr", {31'h0, core_en_o}, 32'h1);
      rxr_i = 0; irxack_i = 0; busy_i = 0; tip_i = 0;

      // Command, done, interrupt and acknowledge flow with EN=1
      apply_stimulus(1, 3'd4, 8'h90, rd, resp);
      check_output("cmd_sta_wr", {27'h0, cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o}, 32'h12);
      pulse(1, 0);
      check_output("cmd_after_done", {27'h0, cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o}, 32'h0);
      apply_stimulus(0, 3'd4, 8'h00, rd, resp);
      check_output("sr_if_set", {24'h0, rd}, 32'h01);
      apply_stimulus(1, 3'd2, 8'hC0, rd, resp);
      check_output("inta_on", {31'h0, wb_inta_o}, 32'h1);
      apply_stimulus(1, 3'd4, 8'h01, rd, resp);
      check_output("inta_off", {31'h0, wb_inta_o}, 32'h0);
      apply_stimulus(0, 3'd4, 8'h00, rd, resp);
      check_output("sr_if_clear", {24'h0, rd}, 32'h00);

      // IACK pulse cycle coinciding with done_i: the set must win
      @(negedge clk);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 3'd4; bus.wb_dat_i = 8'h01;
      @(posedge clk); #1;
      check_output("iack_wr_ack", {31'h0, bus.wb_ack_o}, 32'h1);
      @(posedge clk); #1;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
      done_i = 1;
      @(posedge clk); #1;
      done_i = 0;
      apply_stimulus(0, 3'd4, 8'h00, rd, resp);
      check_output("sr_if_set_wins", {24'h0, rd}, 32'h01);

      // Arbitration lost clears commands and sets AL; STA write clears AL
      apply_stimulus(1, 3'd4, 8'h10, rd, resp);
      pulse(0, 1);
      check_output("cmd_after_al", {27'h0, cmd_sta_o, cmd_sto_o, cmd_rd_o, cmd_wr_o, cmd_ack_o}, 32'h0);
      apply_stimulus(0, 3'd4, 8'h00, rd, resp);
      check_output("sr_al_if", {24'h0, rd}, 32'h21);
      apply_stimulus(1, 3'd4, 8'h80, rd, resp);
      apply_stimulus(0, 3'd4, 8'h00, rd, resp);
      check_output("sr_al_cleared", {24'h0, rd}, 32'h01);
      check_output("sta_held", {31'h0, cmd_sta_o}, 32'h1);

      // Strobe held high: ack every other cycle, then reset drops everything
      @(negedge clk);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 3'd2;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         check_output($sformatf("held_ack_%0d", k), {31'h0, bus.wb_ack_o}, {31'h0, k[0]});
      end
      rst_n = 0;
      @(posedge clk); #1;
      check_output("ack_reset_1", {31'h0, bus.wb_ack_o}, 32'h0);
      @(posedge clk); #1;
      check_output("ack_reset_2", {31'h0, bus.wb_ack_o}, 32'h0);
      check_output("state_reset", dut_outs(), {16'hFFFF, 16'h0000});
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      @(negedge clk);
      rst_n = 1;

      // cyc low with stb high is not a request
      @(negedge clk);
      bus.wb_cyc_i = 0; bus.wb_stb_i = 1;
      @(posedge clk); #1;
      check_output("stb_no_cyc", {31'h0, bus.wb_ack_o}, 32'h0);
      bus.wb_stb_i = 0;

`ifdef I2C_WB_ERR_EN
      apply_stimulus(0, 3'd6, 8'h00, rd, resp);
      check_output("err_adr6", {30'h0, resp}, 32'h2);
      apply_stimulus(1, 3'd4, 8'h90, rd, resp);
      check_output("err_cr_en0", {30'h0, resp}, 32'h2);
      check_output("cr_ignored", {31'h0, cmd_sta_o}, 32'h0);
`endif

      // Randomized phase against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 200; n++) begin
         int op;
         logic [2:0] adr;
         logic [7:0] d;
         op  = $urandom_range(0, 5);
         adr = 3'($urandom_range(0, 7));
         d   = 8'($urandom);
         if (op <= 1) begin
            pre = model_bad(1, adr);
            apply_stimulus(1, adr, d, rd, resp);
            check_output($sformatf("rnd%0d_wresp", n), {30'h0, resp}, pre ? 32'h2 : 32'h1);
            if (!pre) model_write(adr, d);
         end else if (op <= 3) begin
            rxr_i = 8'($urandom); irxack_i = 1'($urandom);
            busy_i = 1'($urandom); tip_i = 1'($urandom);
            pre = model_bad(0, adr);
            apply_stimulus(0, adr, 8'h00, rd, resp);
            check_output($sformatf("rnd%0d_rresp", n), {30'h0, resp}, pre ? 32'h2 : 32'h1);
            if (!pre)
               check_output($sformatf("rnd%0d_rd_adr%0d", n, adr), {24'h0, rd}, {24'h0, model_read(adr)});
         end else begin
            pulse(op == 4, op == 5);
            m_cmd[4:1] = 4'b0000;
            m_if = 1'b1;
            if (op == 5) m_al = 1'b1;
         end
         check_output($sformatf("rnd%0d_outs", n), dut_outs(), model_outs());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
